// File: rtl/servo_pkg.sv
// servo_pkg: shared definitions for the servo PWM capture and generator blocks.
//   - cap_state_e   : capture FSM state encoding
//   - SERVO_*       : default pulse limits, frame period and loss timeout
//   - ticks_per_us  : clocks per microsecond derived from the clock frequency
//   - cnt_width     : counter width able to hold 0..max_val-1 (at least 1 bit)
package servo_pkg;

    typedef enum logic [1:0] {
        StSync,
        StWaitRise,
        StHigh
    } cap_state_e;

    localparam int unsigned SERVO_MIN_US     = 1_000;
    localparam int unsigned SERVO_MAX_US     = 2_000;
    localparam int unsigned SERVO_FRAME_US   = 20_000;
    localparam int unsigned SERVO_TIMEOUT_US = 40_000;

    // Clocks slower than 1 MHz degrade to one tick per clock.
    function automatic int unsigned ticks_per_us(input int unsigned clk_hz);
        return (clk_hz < 1_000_000) ? 1 : clk_hz / 1_000_000;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: two-flop synchronizer for an asynchronous line plus edge detect.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   din      : asynchronous input line
//   rise     : synchronized line went 0 -> 1 (combinational, one cycle)
//   fall     : synchronized line went 1 -> 0 (combinational, one cycle)
//   level    : synchronized line value
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: measures the high time of a servo PWM line in microseconds.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   pwm_in      : asynchronous servo PWM line
//   width_us    : last accepted pulse width in microseconds
//   width_valid : one-cycle strobe, width_us updated
//   range_err   : one-cycle strobe, pulse outside MIN..MAX
//   signal_lost : level, no rising edge for TIMEOUT_US (set in reset)
// Build option: SERVO_PWM_CAPTURE_CLAMP_EN reports out-of-range pulses clamped to
// MIN/MAX with width_valid and range_err together; otherwise only range_err fires.
module servo_pwm_capture
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ             = 50_000_000,
    parameter int unsigned MIN_PULSE_WIDTH_US = SERVO_MIN_US,
    parameter int unsigned MAX_PULSE_WIDTH_US = SERVO_MAX_US,
    parameter int unsigned TIMEOUT_US         = SERVO_TIMEOUT_US
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [15:0] width_us,
    output logic        width_valid,
    output logic        range_err,
    output logic        signal_lost
);

    localparam int unsigned TPU = ticks_per_us(CLK_HZ);
    localparam int unsigned PW  = cnt_width(TPU);
    localparam int unsigned TW  = cnt_width(TIMEOUT_US + 1);
    localparam logic [15:0] MIN_W = 16'(MIN_PULSE_WIDTH_US);
    localparam logic [15:0] MAX_W = 16'(MAX_PULSE_WIDTH_US);

    logic rise, fall, level;

    pwm_edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .rise  (rise),
        .fall  (fall),
        .level (level)
    );

    cap_state_e  state_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   width_q;
    logic [TW-1:0] to_q;
    logic [1:0]    prime_q;

    logic          tick;
    logic          sync_ready;
    logic          timeout_hit;
    logic [15:0]   width_now;
    logic          in_range;

    always_comb begin
        tick        = (presc_q == PW'(TPU - 1));
        // Synchronizer output is meaningless until two samples have shifted in.
        sync_ready  = (prime_q == 2'd2);
        timeout_hit = tick && (to_q == TW'(TIMEOUT_US - 1));
        // Include the tick landing on this cycle so an exact N us pulse reads N.
        width_now   = (tick && width_q != 16'hFFFF) ? width_q + 16'd1 : width_q;
        in_range    = (width_now >= MIN_W) && (width_now <= MAX_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSync;
            presc_q     <= '0;
            width_q     <= '0;
            to_q        <= '0;
            prime_q     <= '0;
            width_us    <= '0;
            width_valid <= 1'b0;
            range_err   <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            width_valid <= 1'b0;
            range_err   <= 1'b0;
            if (!sync_ready) prime_q <= prime_q + 2'd1;
            presc_q <= (rise || tick) ? '0 : presc_q + PW'(1);

            unique case (state_q)
                StSync: begin
                    // A pulse already in progress is skipped: wait for a real low.
                    to_q <= '0;
                    if (sync_ready && !level) state_q <= StWaitRise;
                end
                StWaitRise, StHigh: begin
                    if (rise) begin
                        width_q <= '0;
                        to_q    <= '0;
                        state_q <= StHigh;
                    end else if (timeout_hit) begin
                        signal_lost <= 1'b1;
                        to_q        <= '0;
                        state_q     <= StSync;
                    end else begin
                        if (tick) to_q <= to_q + TW'(1);
                        if (state_q == StHigh) begin
                            width_q <= width_now;
                            if (fall) begin
                                state_q <= StWaitRise;
                                if (in_range) begin
                                    width_us    <= width_now;
                                    width_valid <= 1'b1;
                                    signal_lost <= 1'b0;
                                end else begin
                                    range_err <= 1'b1;
`ifdef SERVO_PWM_CAPTURE_CLAMP_EN
                                    width_us    <= (width_now < MIN_W) ? MIN_W : MAX_W;
                                    width_valid <= 1'b1;
                                    signal_lost <= 1'b0;
`endif
                                end
                            end
                        end
                    end
                end
                default: state_q <= StSync;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture at a scaled-down clock (4 ticks/us) and short
// timings so every scenario, including the loss timeout, fits in a short run.
module tb_servo_pwm_capture;

    localparam int unsigned CLK_HZ = 4_000_000;
    localparam int          TPU    = 4;
    localparam int          MIN_US = 100;
    localparam int          MAX_US = 200;
    localparam int          TO_US  = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [15:0] width_us;
    logic        width_valid;
    logic        range_err;
    logic        signal_lost;

    always #5 clk = ~clk;

    servo_pwm_capture #(
        .CLK_HZ             (CLK_HZ),
        .MIN_PULSE_WIDTH_US (MIN_US),
        .MAX_PULSE_WIDTH_US (MAX_US),
        .TIMEOUT_US         (TO_US)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .width_us    (width_us),
        .width_valid (width_valid),
        .range_err   (range_err),
        .signal_lost (signal_lost)
    );

    int n_checks = 0;
    int n_errors = 0;
    int win_valid, win_err, win_first, win_k;
    int n_both   = 0;
    int exp_both = 0;
    // Reference state: what width_us / signal_lost should currently hold.
    int m_width;
    int m_lost;

    always @(negedge clk) if (width_valid === 1'b1 && range_err === 1'b1) n_both++;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_win();
        win_valid = 0;
        win_err   = 0;
        win_first = -1;
        win_k     = 0;
    endtask

    // Advance n cycles, sampling outputs on each falling edge.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            win_k++;
            if (width_valid === 1'b1) begin
                win_valid++;
                if (win_first < 0) win_first = win_k;
            end
            if (range_err === 1'b1) begin
                win_err++;
                if (win_first < 0) win_first = win_k;
            end
        end
    endtask

    // Expected outcome of one measured pulse of hi clocks; updates the model.
    task automatic model_pulse(input int hi, output int ev, output int ee);
        int w;
        w  = hi / TPU;
        if (w > 65535) w = 65535;
        ev = 0;
        ee = 0;
        if (w >= MIN_US && w <= MAX_US) begin
            ev      = 1;
            m_width = w;
            m_lost  = 0;
        end else begin
            ee = 1;
`ifdef SERVO_PWM_CAPTURE_CLAMP_EN
            ev      = 1;
            m_width = (w < MIN_US) ? MIN_US : MAX_US;
            m_lost  = 0;
            exp_both++;
`endif
        end
    endtask

    task automatic send_pulse(input int hi, input int lo, input bit measured);
        int ev, ee;
        clear_win();
        pwm_in = 1'b1;
        tick_n(hi);
        check_eq("strobe_while_high", win_valid + win_err, 0);
        pwm_in = 1'b0;
        clear_win();
        tick_n(lo);
        ev = 0;
        ee = 0;
        if (measured) model_pulse(hi, ev, ee);
        check_eq("valid_count", win_valid, ev);
        check_eq("range_err_count", win_err, ee);
        if (ev + ee > 0) check_eq("strobe_latency", win_first, 3);
        check_eq("width_us", int'(width_us), m_width);
        check_eq("signal_lost", int'(signal_lost), m_lost);
    endtask

    // Rise, stay high for hi clocks, then low; loss must appear exactly
    // TO_US after the rise (plus the fixed 3-clock input latency).
    task automatic timeout_run(input int hi);
        int last, ev, ee;
        last = ((hi > TO_US * TPU + 3) ? hi : TO_US * TPU + 3) + 8;
        ev = 0;
        ee = 0;
        if (hi < TO_US * TPU) model_pulse(hi, ev, ee);
        clear_win();
        pwm_in = 1'b1;
        for (int n = 1; n <= last; n++) begin
            tick_n(1);
            if (n == TO_US * TPU + 2) check_eq("lost_before_timeout", int'(signal_lost), 0);
            if (n == TO_US * TPU + 3) check_eq("lost_at_timeout", int'(signal_lost), 1);
            if (n == hi) pwm_in = 1'b0;
        end
        m_lost = 1;
        check_eq("timeout_valid_count", win_valid, ev);
        check_eq("timeout_err_count", win_err, ee);
        check_eq("timeout_width_us", int'(width_us), m_width);
    endtask

    initial begin
        int hi, lo;
        rst     = 1'b1;
        pwm_in  = 1'b0;
        m_width = 0;
        m_lost  = 1;
        repeat (3) @(negedge clk);
        check_eq("rst_width_us", int'(width_us), 0);
        check_eq("rst_width_valid", int'(width_valid), 0);
        check_eq("rst_range_err", int'(range_err), 0);
        check_eq("rst_signal_lost", int'(signal_lost), 1);

        // Line already high at reset release: that pulse must be ignored.
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_win();
        tick_n(70 * TPU);
        pwm_in = 1'b0;
        tick_n(50 * TPU);
        check_eq("partial_pulse_ignored", win_valid + win_err, 0);
        check_eq("partial_lost_kept", int'(signal_lost), 1);
        send_pulse(120 * TPU, 60 * TPU, 1'b1);

        // Steady frames.
        repeat (3) send_pulse(150 * TPU, 150 * TPU, 1'b1);

        // Range boundaries and truncation.
        send_pulse(MIN_US * TPU, 40 * TPU, 1'b1);
        send_pulse(MAX_US * TPU, 40 * TPU, 1'b1);
        send_pulse(MIN_US * TPU - 1, 40 * TPU, 1'b1);
        send_pulse(MAX_US * TPU + TPU - 1, 40 * TPU, 1'b1);
        send_pulse((MAX_US + 1) * TPU, 40 * TPU, 1'b1);
        send_pulse(250 * TPU, 40 * TPU, 1'b1);
        send_pulse(50 * TPU, 40 * TPU, 1'b1);

        // Random pulses around the legal window with sub-microsecond jitter.
        for (int i = 0; i < 24; i++) begin
            hi = int'($urandom_range(MAX_US + 30, MIN_US - 30)) * TPU
               + int'($urandom_range(TPU - 1, 0));
            lo = int'($urandom_range(100, 20)) * TPU + int'($urandom_range(TPU - 1, 0));
            send_pulse(hi, lo, 1'b1);
        end

        // Loss with the line parked low, then recovery.
        timeout_run(150 * TPU);
        send_pulse(150 * TPU, 80 * TPU, 1'b1);

        // Loss with the line stuck high; the late fall must not be measured.
        timeout_run(TO_US * TPU + 10);
        send_pulse(160 * TPU, 80 * TPU, 1'b1);

        // Reset in the middle of a pulse.
        clear_win();
        pwm_in = 1'b1;
        tick_n(80 * TPU);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_width_us", int'(width_us), 0);
        check_eq("async_rst_width_valid", int'(width_valid), 0);
        check_eq("async_rst_range_err", int'(range_err), 0);
        check_eq("async_rst_signal_lost", int'(signal_lost), 1);
        m_width = 0;
        m_lost  = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick_n(70 * TPU);
        pwm_in = 1'b0;
        tick_n(60 * TPU);
        check_eq("interrupted_no_strobe", win_valid + win_err, 0);
        check_eq("interrupted_width_us", int'(width_us), 0);
        send_pulse(130 * TPU, 60 * TPU, 1'b1);

        check_eq("valid_and_err_together", n_both, exp_both);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
